lisp_memory: RTL and testbench

- Word-addressed main store for the Lisp machine: MemorySize words of 16 bits, holding typed cells (tag word followed by payload words).
- Provides one synchronous read port, one synchronous write port and a bump allocator that hands out contiguous cell space.
- Sits between the evaluator/CPU datapath and the storage array. Benches preload the internal array, named `memory`, hierarchically.

---
 rtl/lisp_memory.sv | 93 +++++++++
 tb/tb_lisp_memory.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lisp_memory.sv
// Word-addressed main store for the Lisp machine: one synchronous read port,
// one synchronous write port and a bump allocator for contiguous cell space.
module lisp_memory #(
   parameter int unsigned MemorySize = 1024,
   parameter int unsigned HeapBase   = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr_in,
   output logic [15:0] data_out,
   input  logic        we_in,
   input  logic [15:0] wdata_in,
   input  logic        alloc_in,
   input  logic [7:0]  alloc_words_in,
   output logic [15:0] alloc_ptr_out,
   output logic        alloc_valid_out,
   output logic        full_out,
   output logic        addr_err_out
);

   localparam int unsigned DataW = 16;
   localparam int unsigned AddrW = (MemorySize > 1) ? $clog2(MemorySize) : 1;

   logic [DataW-1:0] memory [0:MemorySize-1];

   logic             addr_ok_c;
   logic [AddrW-1:0] idx_c;
   logic [7:0]       n_c;
   logic [16:0]      sum_c;
   logic             fit_c;

   logic [DataW-1:0] data_q;
   logic [15:0]      fp_q, fp_d;
   logic [15:0]      ptr_q, ptr_d;
   logic             valid_q, valid_d;
   logic             full_q, full_d;
   logic             err_q;

   assign addr_ok_c = 32'(addr_in) < MemorySize;
   assign idx_c     = addr_in[AddrW-1:0];

   // Allocator next state; a zero-word request is promoted to one word.
   always_comb begin
      n_c     = (alloc_words_in == 8'd0) ? 8'd1 : alloc_words_in;
      sum_c   = 17'(fp_q) + 17'(n_c);
      fit_c   = sum_c <= 17'(MemorySize);
      fp_d    = fp_q;
      ptr_d   = ptr_q;
      valid_d = 1'b0;
      full_d  = full_q;
      if (alloc_in) begin
         if (fit_c) begin
            ptr_d   = fp_q;
            fp_d    = sum_c[15:0];
            valid_d = 1'b1;
         end else begin
            full_d  = 1'b1;
         end
      end
   end

   // Storage is never reset so preloaded contents survive; a write racing reset is dropped.
   always_ff @(posedge clk) begin
      if (!rst && we_in && addr_ok_c) begin
         memory[idx_c] <= wdata_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         err_q   <= 1'b0;
         fp_q    <= 16'(HeapBase);
         ptr_q   <= '0;
         valid_q <= 1'b0;
         full_q  <= 1'b0;
      end else begin
         data_q  <= addr_ok_c ? memory[idx_c] : '0;
         err_q   <= !addr_ok_c;
         fp_q    <= fp_d;
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
         full_q  <= full_d;
      end
   end

   assign data_out        = data_q;
   assign addr_err_out    = err_q;
   assign alloc_ptr_out   = ptr_q;
   assign alloc_valid_out = valid_q;
   assign full_out        = full_q;

endmodule

// File: tb/tb_lisp_memory.sv
// Scoreboard bench for lisp_memory: a reference model predicts each edge's
// outputs, queues them, and they are compared one cycle later.
module tb_lisp_memory;

   localparam int unsigned MemSize  = 1024;
   localparam int unsigned HeapB    = 0;
   localparam logic [14:0] TypeNumber = 15'd1;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addr_in;
   logic [15:0] data_out;
   logic        we_in;
   logic [15:0] wdata_in;
   logic        alloc_in;
   logic [7:0]  alloc_words_in;
   logic [15:0] alloc_ptr_out;
   logic        alloc_valid_out;
   logic        full_out;
   logic        addr_err_out;

   typedef struct packed {
      logic [15:0] data;
      logic [15:0] ptr;
      logic        valid;
      logic        full;
      logic        err;
   } exp_t;

   exp_t        sb_q[$];
   logic [15:0] mdl [0:MemSize-1];
   int          m_fp;
   logic [15:0] m_ptr;
   logic        m_full;
   int          n_checks = 0;
   int          n_errors = 0;

   lisp_memory #(.MemorySize(MemSize), .HeapBase(HeapB)) dut (
      .clk(clk), .rst(rst), .addr_in(addr_in), .data_out(data_out),
      .we_in(we_in), .wdata_in(wdata_in), .alloc_in(alloc_in),
      .alloc_words_in(alloc_words_in), .alloc_ptr_out(alloc_ptr_out),
      .alloc_valid_out(alloc_valid_out), .full_out(full_out),
      .addr_err_out(addr_err_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One cycle: drive at negedge, predict, then compare after the rising edge.
   task automatic step(input logic [15:0] a, input logic we, input logic [15:0] wd,
                       input logic al, input logic [7:0] words);
      exp_t e;
      exp_t got;
      int   n;
      @(negedge clk);
      addr_in = a; we_in = we; wdata_in = wd; alloc_in = al; alloc_words_in = words;
      e.data  = (int'(a) < MemSize) ? mdl[a[9:0]] : 16'h0000;
      if (we && int'(a) < MemSize) mdl[a[9:0]] = wd;
      e.err   = int'(a) >= MemSize;
      e.valid = 1'b0;
      if (al) begin
         n = (words == 8'd0) ? 1 : int'(words);
         if (m_fp + n <= MemSize) begin
            m_ptr   = 16'(m_fp);
            m_fp    = m_fp + n;
            e.valid = 1'b1;
         end else begin
            m_full  = 1'b1;
         end
      end
      e.ptr  = m_ptr;
      e.full = m_full;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      check("data_out", data_out, got.data);
      check("alloc_ptr_out", alloc_ptr_out, got.ptr);
      check("alloc_valid_out", 16'(alloc_valid_out), 16'(got.valid));
      check("full_out", 16'(full_out), 16'(got.full));
      check("addr_err_out", 16'(addr_err_out), 16'(got.err));
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_data"}, data_out, 16'h0000);
      check({tag, "_ptr"}, alloc_ptr_out, 16'h0000);
      check({tag, "_valid"}, 16'(alloc_valid_out), 16'h0000);
      check({tag, "_full"}, 16'(full_out), 16'h0000);
      check({tag, "_err"}, 16'(addr_err_out), 16'h0000);
   endtask

   initial begin
      rst = 1'b1;
      addr_in = '0; we_in = 1'b0; wdata_in = '0; alloc_in = 1'b0; alloc_words_in = '0;
      for (int i = 0; i < int'(MemSize); i++) begin
         dut.memory[i] = 16'h0000;
         mdl[i] = 16'h0000;
      end
      dut.memory[0] = {1'b0, TypeNumber};
      mdl[0]        = {1'b0, TypeNumber};
      dut.memory[1] = 16'h2A2A;
      mdl[1]        = 16'h2A2A;
      m_fp = int'(HeapB); m_ptr = '0; m_full = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_cleared("reset");
      @(negedge clk);
      rst = 1'b0;

      // Preloaded read, two edges at the same address.
      step(16'd1, 1'b0, 16'h0, 1'b0, 8'd0);
      step(16'd1, 1'b0, 16'h0, 1'b0, 8'd0);
      check("preload_read", data_out, 16'h2A2A);
      step(16'd0, 1'b0, 16'h0, 1'b0, 8'd0);
      check("tag_word", data_out, {1'b0, TypeNumber});

      // Read-first write, then visibility.
      step(16'd5, 1'b1, 16'hBEEF, 1'b0, 8'd0);
      check("rd_first_old", data_out, 16'h0000);
      step(16'd5, 1'b0, 16'h0, 1'b0, 8'd0);
      check("rd_after_wr", data_out, 16'hBEEF);

      // Out-of-range access is flagged and the write is dropped.
      step(16'd1024, 1'b1, 16'h1111, 1'b0, 8'd0);
      check("oor_err", 16'(addr_err_out), 16'h0001);
      step(16'd1023, 1'b0, 16'h0, 1'b0, 8'd0);
      check("edge_err", 16'(addr_err_out), 16'h0000);
      step(16'hFFFF, 1'b0, 16'h0, 1'b0, 8'd0);
      step(16'd0, 1'b0, 16'h0, 1'b0, 8'd0);

      // Allocation sequence from HeapBase.
      step(16'd0, 1'b0, 16'h0, 1'b1, 8'd2);
      check("alloc_first", alloc_ptr_out, 16'd0);
      step(16'd0, 1'b0, 16'h0, 1'b1, 8'd3);
      check("alloc_second", alloc_ptr_out, 16'd2);
      step(16'd0, 1'b0, 16'h0, 1'b0, 8'd0);
      step(16'd0, 1'b0, 16'h0, 1'b1, 8'd0);
      check("alloc_zero_words", alloc_ptr_out, 16'd5);

      // Fill to 1022, exact fit, then exhaustion.
      for (int i = 0; i < 3; i++) step(16'd2, 1'b0, 16'h0, 1'b1, 8'd255);
      step(16'd2, 1'b0, 16'h0, 1'b1, 8'd251);
      step(16'd2, 1'b0, 16'h0, 1'b1, 8'd2);
      check("exact_fit_ptr", alloc_ptr_out, 16'd1022);
      check("exact_fit_valid", 16'(alloc_valid_out), 16'h0001);
      step(16'd2, 1'b0, 16'h0, 1'b1, 8'd1);
      check("full_set", 16'(full_out), 16'h0001);
      check("full_no_valid", 16'(alloc_valid_out), 16'h0000);

      // Mixed random traffic, including out-of-range addresses.
      for (int i = 0; i < 60; i++) begin
         step(16'($urandom_range(0, 1100)), 1'($urandom_range(0, 1)),
              16'($urandom), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      end
      for (int i = 0; i < 20; i++) step(16'($urandom_range(0, 1023)), 1'b0, 16'h0, 1'b0, 8'd0);

      // Reset mid-operation: outputs clear at once, racing write lost, storage kept.
      @(negedge clk);
      dut.memory[7] = 16'h1234;
      mdl[7]        = 16'h1234;
      addr_in = 16'd7; we_in = 1'b1; wdata_in = 16'hFFFF; alloc_in = 1'b1; alloc_words_in = 8'd4;
      #1 rst = 1'b1;
      #1;
      check_cleared("async_rst");
      @(posedge clk);
      #1;
      check_cleared("held_rst");
      m_fp = int'(HeapB); m_ptr = '0; m_full = 1'b0;
      @(negedge clk);
      rst = 1'b0; we_in = 1'b0; alloc_in = 1'b0;
      step(16'd7, 1'b0, 16'h0, 1'b0, 8'd0);
      check("kept_after_rst", data_out, 16'h1234);
      step(16'd7, 1'b0, 16'h0, 1'b1, 8'd4);
      check("fp_restart", alloc_ptr_out, 16'(HeapB));
      step(16'd7, 1'b0, 16'h0, 1'b1, 8'd1);
      check("fp_advance", alloc_ptr_out, 16'(HeapB + 4));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
